// File: rtl/cpu_defs.sv
// Shared fetch-stage definitions: FSM encodings, exception codes, legal PC window
// and the fetch FIFO entry layout.
package cpu_defs;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    localparam logic [31:0] PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_MAX     = 32'h0000_6FFC;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Word-aligned and inside the instruction memory window.
    function automatic logic pc_in_range(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc >= PC_DEFAULT) && (pc <= PC_MAX);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch FIFO: DEPTH entries of {instr, pc, exc}, flush clears it in one cycle.
// Head is forced to zero while empty so decode never sees stale data.
module fetch_fifo
    import cpu_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic               head_valid,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    fetch_entry_t     mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop.
    assign do_push = push & ~flush;
    assign do_pop  = pop & head_valid & ~flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage has no reset; contents are only observable through head,
    // which is qualified by count, so a reset here would only cost area.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    assign head_valid = (count != '0);
    assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: one outstanding imem request, PC enable control and a
// tagged FIFO toward decode. Define FETCH_ADDR_CHECK_EN to raise AdEL on bad PCs.
module fetch_buffer
    import cpu_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_i,
    output logic             pc_en_o,
    input  logic             flush_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [31:0]      id_instr_o,
    output logic [31:0]      id_pc_o,
    output logic [4:0]       id_exc_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc_q;
    logic [CNT_W:0] occupancy;
    logic         space;
    logic         addr_bad;
    logic         can_issue;
    logic         grant;
    logic         exc_push;
    logic         rsp_push;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    // An outstanding request reserves a slot, so a response can never hit a full FIFO.
    assign occupancy = {1'b0, count_o} + (CNT_W+1)'(state != FETCH);
    assign space     = occupancy < (CNT_W+1)'(DEPTH);

`ifdef FETCH_ADDR_CHECK_EN
    assign addr_bad = !pc_in_range(pc_i);
`else
    assign addr_bad = 1'b0;
`endif

    assign can_issue   = reset & (state == FETCH) & space & ~flush_i;
    assign imem_req_o  = can_issue & ~addr_bad;
    assign imem_addr_o = pc_i;
    assign grant       = imem_req_o & imem_gnt_i;
    assign exc_push    = can_issue & addr_bad;
    assign pc_en_o     = reset & (grant | flush_i | exc_push);
    assign rsp_push    = (state == WAIT) & imem_rvalid_i & ~flush_i;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        push_entry = '{instr: imem_rdata_i, pc: pc_q, exc: EXC_NONE};
        if (exc_push) push_entry = '{instr: 32'h0, pc: pc_i, exc: EXC_ADEL};
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: if (grant) state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid_i)  state_nxt = FETCH;
                else if (flush_i)   state_nxt = DROP;
            end
            DROP:  if (imem_rvalid_i) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc_q  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) pc_q <= pc_i;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_i),
        .push       (rsp_push | exc_push),
        .push_entry (push_entry),
        .pop        (id_valid_o & id_ready_i),
        .head       (head),
        .head_valid (id_valid_o),
        .count      (count_o)
    );

    assign id_instr_o = head.instr;
    assign id_pc_o    = head.pc;
    assign id_exc_o   = head.exc;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a memory responder pushes expected entries
// into a scoreboard, a monitor pops and compares whatever decode accepts.
module tb_fetch_buffer;
    import cpu_defs::*;

    logic        clk;
    logic        reset;
    logic [31:0] pc_i;
    logic        pc_en_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [4:0]  id_exc_o;
    logic [2:0]  count_o;

    logic        gnt_en;
    logic [31:0] redirect;
    int          lat;
    logic        busy;
    logic        killed;
    int          n_checks;
    int          n_fail;
    fetch_entry_t sb[$];

    fetch_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_i          (pc_i),
        .pc_en_o       (pc_en_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_exc_o      (id_exc_o),
        .count_o       (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_gnt_i = imem_req_o & gnt_en;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'h2408_0001 + ((a - 32'h0000_3000) >> 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [31:0] tgt);
        flush_i  = 1'b1;
        redirect = tgt;
        if (busy) killed = 1'b1;
        sb.delete();
    endtask

    task automatic wait_count(input logic [2:0] n);
        int i;
        i = 0;
        @(negedge clk);
        while (count_o != n && i < 40) begin
            @(negedge clk);
            i++;
        end
        check("wait_count", 32'(count_o), 32'(n));
    endtask

    task automatic drain();
        int i;
        tick();
        gnt_en     = 1'b0;
        id_ready_i = 1'b1;
        i = 0;
        @(negedge clk);
        while ((busy || count_o != 3'd0) && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("drain_count", 32'(count_o), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    // PC register model: loads redirect on flush, advances by 4 on enable.
    initial begin
        logic en, fl;
        logic [31:0] tgt;
        pc_i = 32'h0000_3000;
        forever begin
            @(negedge clk);
            en  = pc_en_o;
            fl  = flush_i;
            tgt = redirect;
            @(posedge clk);
            #1;
            if (!reset)   pc_i = 32'h0000_3000;
            else if (fl)  pc_i = tgt;
            else if (en)  pc_i = pc_i + 32'd4;
        end
    end

    // Memory responder: one request at a time, rvalid lat cycles after grant.
    initial begin
        logic [31:0] addr;
        int l;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        busy          = 1'b0;
        killed        = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req_o && imem_gnt_i) begin
                addr = imem_addr_o;
                busy = 1'b1;
                l    = lat;
                tick();
                repeat (l - 1) tick();
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_data(addr);
                @(negedge clk);
                if (!flush_i && !killed)
                    sb.push_back('{instr: mem_data(addr), pc: addr, exc: EXC_NONE});
                tick();
                imem_rvalid_i = 1'b0;
                busy          = 1'b0;
                killed        = 1'b0;
            end
        end
    end

    // Monitor: every entry accepted by decode must match the scoreboard head.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (reset && id_valid_o && id_ready_i && !flush_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_entry: got pc 0x%08h, expected none", id_pc_o);
                end else begin
                    e = sb.pop_front();
                    check("mon_instr", id_instr_o, e.instr);
                    check("mon_pc", id_pc_o, e.pc);
                    check("mon_exc", 32'(id_exc_o), 32'(e.exc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int grants, pulses;
        logic found;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        flush_i    = 1'b0;
        id_ready_i = 1'b0;
        gnt_en     = 1'b0;
        redirect   = '0;
        lat        = 1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_pc_en", 32'(pc_en_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_valid", 32'(id_valid_o), 32'd0);
        check("rst_instr", id_instr_o, 32'd0);
        check("rst_pc", id_pc_o, 32'd0);
        check("rst_exc", 32'(id_exc_o), 32'd0);

        // Basic fetch
        tick();
        reset = 1'b1; gnt_en = 1'b1; id_ready_i = 1'b1; lat = 1;
        @(negedge clk);
        check("basic_req", 32'(imem_req_o), 32'd1);
        check("basic_addr", imem_addr_o, 32'h0000_3000);
        check("basic_pc_en_grant", 32'(pc_en_o), 32'd1);
        tick();
        gnt_en = 1'b0;
        @(negedge clk);
        check("basic_pc_en_wait", 32'(pc_en_o), 32'd0);
        check("basic_req_wait", 32'(imem_req_o), 32'd0);
        tick();
        @(negedge clk);
        check("basic_valid", 32'(id_valid_o), 32'd1);
        check("basic_id_pc", id_pc_o, 32'h0000_3000);
        check("basic_id_instr", id_instr_o, 32'h2408_0001);
        drain();

        // Full back-pressure
        tick();
        id_ready_i = 1'b0; gnt_en = 1'b1; lat = 1;
        grants = 0; pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (imem_req_o && imem_gnt_i) grants++;
            if (pc_en_o) pulses++;
        end
        check("bp_grants", 32'(grants), 32'd4);
        check("bp_pc_en_pulses", 32'(pulses), 32'd4);
        check("bp_req_stalled", 32'(imem_req_o), 32'd0);
        check("bp_count_full", 32'(count_o), 32'd4);
        tick();
        id_ready_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (imem_req_o) found = 1'b1;
        end
        check("bp_resume_req", 32'(found), 32'd1);
        drain();

        // Flush while a request is outstanding
        tick();
        gnt_en = 1'b0;
        do_flush(32'h0000_3008);
        tick();
        flush_i = 1'b0; lat = 3; gnt_en = 1'b1;
        @(negedge clk);
        check("fw_addr", imem_addr_o, 32'h0000_3008);
        check("fw_grant", 32'(imem_req_o & imem_gnt_i), 32'd1);
        tick();
        gnt_en = 1'b0;
        do_flush(32'h0000_3200);
        @(negedge clk);
        check("fw_pc_en_flush", 32'(pc_en_o), 32'd1);
        check("fw_req_flush", 32'(imem_req_o), 32'd0);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        check("fw_drop_req", 32'(imem_req_o), 32'd0);
        tick();
        @(negedge clk);
        check("fw_drop_rvalid_req", 32'(imem_req_o), 32'd0);
        tick();
        @(negedge clk);
        check("fw_back_to_fetch", 32'(imem_req_o), 32'd1);
        check("fw_count", 32'(count_o), 32'd0);
        check("fw_valid", 32'(id_valid_o), 32'd0);

        // Flush coincident with rvalid, FIFO holding two entries
        tick();
        id_ready_i = 1'b0; lat = 2; gnt_en = 1'b1;
        wait_count(3'd2);
        tick();
        gnt_en = 1'b0;
        tick();
        do_flush(32'h0000_3100);
        @(negedge clk);
        check("fr_pc_en", 32'(pc_en_o), 32'd1);
        check("fr_no_req", 32'(imem_req_o), 32'd0);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        check("fr_count", 32'(count_o), 32'd0);
        check("fr_valid", 32'(id_valid_o), 32'd0);
        check("fr_fetch_req", 32'(imem_req_o), 32'd1);

        // Simultaneous push and pop at count 2
        tick();
        lat = 1; gnt_en = 1'b1;
        wait_count(3'd2);
        tick();
        gnt_en = 1'b0; id_ready_i = 1'b1;
        @(negedge clk);
        check("pp_count_before", 32'(count_o), 32'd2);
        tick();
        @(negedge clk);
        check("pp_count_after", 32'(count_o), 32'd2);
        drain();

`ifdef FETCH_ADDR_CHECK_EN
        // Address check: misaligned, then above the window
        tick();
        gnt_en = 1'b0; id_ready_i = 1'b0;
        do_flush(32'h0000_3002);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        check("ac_no_req", 32'(imem_req_o), 32'd0);
        check("ac_pc_en", 32'(pc_en_o), 32'd1);
        tick();
        @(negedge clk);
        check("ac_valid", 32'(id_valid_o), 32'd1);
        check("ac_id_pc", id_pc_o, 32'h0000_3002);
        check("ac_id_exc", 32'(id_exc_o), 32'd4);
        check("ac_id_instr", id_instr_o, 32'd0);
        tick();
        do_flush(32'h0000_7000);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        check("ac_hi_no_req", 32'(imem_req_o), 32'd0);
        check("ac_hi_pc_en", 32'(pc_en_o), 32'd1);
        tick();
        @(negedge clk);
        check("ac_hi_id_pc", id_pc_o, 32'h0000_7000);
        check("ac_hi_id_exc", 32'(id_exc_o), 32'd4);
        tick();
        do_flush(32'h0000_3000);
        tick();
        flush_i = 1'b0;
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
